// File: rtl/core_inst_seq.sv
// Tile instruction sequencer: walks the core through weight load, activation load,
// execute, output-FIFO drain to pmem and psum accumulation, one registered word per cycle.
module core_inst_seq #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int aw  = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [aw-1:0] num_act,
  input  logic [aw-1:0] w_base,
  input  logic [aw-1:0] a_base,
  input  logic [aw-1:0] p_base,
  input  logic          ofifo_valid,
  output logic [33:0]   inst,
  output logic          busy,
  output logic          done
);

  localparam int cw = aw + 2;
  localparam logic [33:0]   IDLE_WORD = 34'h1_800C_0000;
  localparam logic [cw-1:0] ROW_C     = cw'(row);
  localparam logic [cw-1:0] COL_C     = cw'(col);
  localparam logic [cw-1:0] ONE_C     = cw'(1);
  localparam logic [aw-1:0] ONE_A     = aw'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_L0  = 3'd1,
    W_LD  = 3'd2,
    A_L0  = 3'd3,
    EXEC  = 3'd4,
    DRAIN = 3'd5,
    ACC   = 3'd6,
    FIN   = 3'd7
  } state_t;

  state_t        r_state;
  logic [cw-1:0] r_cnt;
  logic [aw-1:0] r_j;
  logic [aw-1:0] r_num;
  logic [aw-1:0] r_wb;
  logic [aw-1:0] r_ab;
  logic [aw-1:0] r_pb;
  logic          r_xrd_d;
  logic          r_wr_pend;
  logic [33:0]   r_inst;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_nxt;
  logic [cw-1:0] w_cnt_nxt;
  logic [aw-1:0] w_j_nxt;
  logic [33:0]   w_inst_nxt;
  logic          w_xrd;
  logic          w_issue_rd;
  logic          w_wr_pend_nxt;
  logic [cw-1:0] w_n;
  logic [aw-1:0] w_cnt_a;

  assign w_n     = {{(cw-aw){1'b0}}, r_num};
  assign w_cnt_a = r_cnt[aw-1:0];

  // Next state, counters and the instruction word to register on the next edge.
  // l0_wr trails every xmem read by one cycle (SRAM latency), and a pmem write
  // trails every ofifo_rd by one cycle, so both may spill into the next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + ONE_C;
    w_j_nxt       = r_j;
    w_inst_nxt    = IDLE_WORD;
    w_xrd         = 1'b0;
    w_issue_rd    = 1'b0;
    w_wr_pend_nxt = 1'b0;
    w_inst_nxt[2] = r_xrd_d;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_j_nxt   = '0;
        if (start) begin
          w_state_nxt = W_L0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      W_L0: begin
        w_xrd            = 1'b1;
        w_inst_nxt[19]   = 1'b0;
        w_inst_nxt[17:7] = 11'(r_wb + w_cnt_a);
        if (r_cnt == ROW_C - ONE_C) begin
          w_state_nxt = W_LD;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = W_L0;
        end
      end
      W_LD: begin
        if (r_cnt < ROW_C) begin
          w_inst_nxt[3] = 1'b1;
          w_inst_nxt[0] = 1'b1;
        end else begin
          w_inst_nxt[3] = 1'b0;
          w_inst_nxt[0] = 1'b0;
        end
        if (r_cnt == ROW_C + COL_C - ONE_C) begin
          w_state_nxt = A_L0;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = W_LD;
        end
      end
      A_L0: begin
        w_xrd            = 1'b1;
        w_inst_nxt[19]   = 1'b0;
        w_inst_nxt[17:7] = 11'(r_ab + w_cnt_a);
        if (r_cnt == w_n - ONE_C) begin
          w_state_nxt = EXEC;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = A_L0;
        end
      end
      EXEC: begin
        if (r_cnt < w_n) begin
          w_inst_nxt[3] = 1'b1;
          w_inst_nxt[1] = 1'b1;
        end else begin
          w_inst_nxt[3] = 1'b0;
          w_inst_nxt[1] = 1'b0;
        end
        if (r_cnt == w_n + ROW_C + COL_C - ONE_C) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
          w_j_nxt     = '0;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      DRAIN: begin
        // r_cnt counts FIFO pops, r_j counts pmem writes.
        w_issue_rd    = ofifo_valid && (r_cnt < w_n);
        w_inst_nxt[6] = w_issue_rd;
        w_wr_pend_nxt = w_issue_rd;
        w_cnt_nxt     = r_cnt + {{(cw-1){1'b0}}, w_issue_rd};
        if (r_wr_pend) begin
          w_inst_nxt[32]    = 1'b0;
          w_inst_nxt[31]    = 1'b0;
          w_inst_nxt[30:20] = 11'(r_pb + r_j);
          w_j_nxt           = r_j + ONE_A;
          if (r_j == r_num - ONE_A) begin
            w_state_nxt = ACC;
            w_cnt_nxt   = '0;
            w_j_nxt     = '0;
          end else begin
            w_state_nxt = DRAIN;
          end
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      ACC: begin
        w_inst_nxt[33] = 1'b1;
        if (r_cnt < w_n) begin
          w_inst_nxt[32]    = 1'b0;
          w_inst_nxt[31]    = 1'b1;
          w_inst_nxt[30:20] = 11'(r_pb + w_cnt_a);
        end else begin
          w_inst_nxt[32]    = 1'b1;
          w_inst_nxt[31]    = 1'b1;
        end
        if (r_cnt == w_n) begin
          w_state_nxt = FIN;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ACC;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_j_nxt     = '0;
      end
    endcase
  end

  // State, counters, latched tile configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_j       <= '0;
      r_num     <= '0;
      r_wb      <= '0;
      r_ab      <= '0;
      r_pb      <= '0;
      r_xrd_d   <= 1'b0;
      r_wr_pend <= 1'b0;
      r_inst    <= IDLE_WORD;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_j       <= w_j_nxt;
      r_xrd_d   <= w_xrd;
      r_wr_pend <= w_wr_pend_nxt;
      r_inst    <= w_inst_nxt;
      r_busy    <= (r_state != IDLE);
      r_done    <= (r_state == FIN);
      if (r_state == IDLE && start) begin
        r_num <= (num_act == '0) ? ONE_A : num_act;
        r_wb  <= w_base;
        r_ab  <= a_base;
        r_pb  <= p_base;
      end else begin
        r_num <= r_num;
        r_wb  <= r_wb;
        r_ab  <= r_ab;
        r_pb  <= r_pb;
      end
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: stimulus pushes expected SRAM/done events and
// per-tile totals; a negedge monitor pops and compares whatever the DUT emits.
module tb_core_inst_seq;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam logic [2:0] K_XRD = 3'd0, K_PWR = 3'd1, K_PRD = 3'd2, K_DONE = 3'd3, K_XWR = 3'd4;

  typedef struct packed { logic [2:0] kind; logic [10:0] addr; } ev_t;

  logic        clk, reset, start, ofifo_valid;
  logic [10:0] num_act, w_base, a_base, p_base;
  logic [33:0] inst;
  logic        busy, done;

  core_inst_seq #(.row(ROW), .col(COL), .aw(11)) dut (
    .clk(clk), .reset(reset), .start(start), .num_act(num_act),
    .w_base(w_base), .a_base(a_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  ev_t exp_q[$];
  int  tn_q[$];
  int  tb_q[$];

  int c_load, c_exec, c_acc, c_l0rd, c_l0wr, c_ofrd, c_both, c_busy;
  logic prev_valid, prev_ofrd;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ev(input logic [2:0] k, input logic [10:0] a);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: got kind %0d addr %0d, expected no event", k, a);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a) begin
        fails++;
        $display("FAIL event: got kind %0d addr %0d, expected kind %0d addr %0d", k, a, e.kind, e.addr);
      end
    end
  endtask

  task automatic clr_counts();
    c_load = 0; c_exec = 0; c_acc = 0; c_l0rd = 0;
    c_l0wr = 0; c_ofrd = 0; c_both = 0; c_busy = 0;
  endtask

  // Monitor: turns each visible instruction word into events and checks them.
  always @(negedge clk) begin
    if (reset) begin
      clr_counts();
      prev_valid = 1'b0;
      prev_ofrd  = 1'b0;
    end else begin
      c_load += int'(inst[0]);
      c_exec += int'(inst[1]);
      c_l0wr += int'(inst[2]);
      c_l0rd += int'(inst[3]);
      c_ofrd += int'(inst[6]);
      c_acc  += int'(inst[33]);
      c_both += int'(inst[0] & inst[1]);
      c_busy += int'(busy);
      if (!inst[19]) check_ev(inst[18] ? K_XRD : K_XWR, inst[17:7]);
      if (!inst[32]) begin
        if (!inst[31]) begin
          chk("write_follows_ofifo_rd", int'(prev_ofrd), 1);
          check_ev(K_PWR, inst[30:20]);
        end else begin
          check_ev(K_PRD, inst[30:20]);
        end
      end
      if (inst[6]) chk("ofifo_rd_follows_valid", int'(prev_valid), 1);
      if (done) begin
        check_ev(K_DONE, 11'd0);
        if (tn_q.size() == 0) begin
          chk("tile_record_present", 0, 1);
        end else begin
          int n, b;
          n = tn_q.pop_front();
          b = tb_q.pop_front();
          if (b != 0) chk("busy_cycles", c_busy, b);
          chk("load_cycles", c_load, ROW);
          chk("exec_cycles", c_exec, n);
          chk("acc_cycles", c_acc, n + 1);
          chk("l0_rd_cycles", c_l0rd, ROW + n);
          chk("l0_wr_cycles", c_l0wr, ROW + n);
          chk("ofifo_rd_cycles", c_ofrd, n);
          chk("load_exec_overlap", c_both, 0);
        end
        done_cnt++;
        clr_counts();
      end
      prev_valid = ofifo_valid;
      prev_ofrd  = inst[6];
    end
  end

  task automatic push_tile(input int n, input logic [10:0] wb, input logic [10:0] ab,
                           input logic [10:0] pb, input int busy_exp, input bit full);
    ev_t e;
    for (int k = 0; k < ROW; k++) begin e.kind = K_XRD; e.addr = wb + 11'(k); exp_q.push_back(e); end
    for (int k = 0; k < n; k++) begin e.kind = K_XRD; e.addr = ab + 11'(k); exp_q.push_back(e); end
    if (full) begin
      for (int k = 0; k < n; k++) begin e.kind = K_PWR; e.addr = pb + 11'(k); exp_q.push_back(e); end
      for (int k = 0; k < n; k++) begin e.kind = K_PRD; e.addr = pb + 11'(k); exp_q.push_back(e); end
      e.kind = K_DONE; e.addr = 11'd0; exp_q.push_back(e);
      tn_q.push_back(n);
      tb_q.push_back(busy_exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [10:0] n, input logic [10:0] wb,
                          input logic [10:0] ab, input logic [10:0] pb);
    num_act = n; w_base = wb; a_base = ab; p_base = pb;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick(1);
      if (done_cnt != d0) got = 1'b1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_exec(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick(1);
      if (inst[1]) got = 1'b1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: execute never seen", name);
    end
  endtask

  function automatic int tile_len(input int n);
    return ROW + (ROW + COL) + n + (n + ROW + COL) + (n + 1) + (n + 1) + 1;
  endfunction

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    num_act = 11'd0; w_base = 11'd0; a_base = 11'd0; p_base = 11'd0;
    #1;
    tick(2);
    reset = 1'b0;
    chk("reset_inst_hi", int'(inst[33:32]), int'(IDLE_W[33:32]));
    chk("reset_inst_lo", int'(inst[31:0]), int'(IDLE_W[31:0]));
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    tick(1);

    // Short tile, FIFO always valid: 8+16+4+20+5+5+1 busy cycles.
    ofifo_valid = 1'b1;
    push_tile(4, 11'd0, 11'd8, 11'd0, 8 + 16 + 4 + 20 + 5 + 5 + 1, 1'b1);
    do_start(11'd4, 11'd0, 11'd8, 11'd0);
    wait_done("short_tile", 200);
    tick(2);

    // Drain stall: FIFO withheld until well inside DRAIN, then 1,0,0,1,1.
    ofifo_valid = 1'b0;
    push_tile(3, 11'd16, 11'd100, 11'd50, 0, 1'b1);
    do_start(11'd3, 11'd16, 11'd100, 11'd50);
    wait_exec("drain_stall");
    tick(30);
    ofifo_valid = 1'b1; tick(1);
    ofifo_valid = 1'b0; tick(1);
    ofifo_valid = 1'b0; tick(1);
    ofifo_valid = 1'b1; tick(1);
    ofifo_valid = 1'b1; tick(1);
    ofifo_valid = 1'b0;
    wait_done("drain_stall", 100);
    tick(2);

    // Address wrap on all three bases.
    ofifo_valid = 1'b1;
    push_tile(4, 11'd2044, 11'd2046, 11'd2046, tile_len(4), 1'b1);
    do_start(11'd4, 11'd2044, 11'd2046, 11'd2046);
    wait_done("wrap", 200);
    tick(2);

    // Start while busy (during EXEC) must be ignored.
    push_tile(4, 11'd0, 11'd8, 11'd20, tile_len(4), 1'b1);
    do_start(11'd4, 11'd0, 11'd8, 11'd20);
    tick(34);
    do_start(11'd9, 11'd300, 11'd400, 11'd500);
    wait_done("start_while_busy", 200);
    tick(2);

    // num_act = 0 runs as a one-vector tile.
    push_tile(1, 11'd3, 11'd7, 11'd9, tile_len(1), 1'b1);
    do_start(11'd0, 11'd3, 11'd7, 11'd9);
    wait_done("num_act_zero", 200);
    tick(2);

    // Reset mid-tile in a stalled DRAIN: only the loads happen, no done.
    ofifo_valid = 1'b0;
    push_tile(4, 11'd40, 11'd60, 11'd80, 0, 1'b0);
    do_start(11'd4, 11'd40, 11'd60, 11'd80);
    wait_exec("reset_mid_tile");
    tick(30);
    d0 = done_cnt;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_inst_hi", int'(inst[33:32]), int'(IDLE_W[33:32]));
    chk("abort_inst_lo", int'(inst[31:0]), int'(IDLE_W[31:0]));
    chk("abort_busy", int'(busy), 0);
    // Reset and start together: reset wins, sequencer stays idle.
    reset = 1'b1; start = 1'b1; num_act = 11'd5;
    tick(1);
    reset = 1'b0; start = 1'b0;
    tick(3);
    chk("reset_beats_start_busy", int'(busy), 0);
    chk("abort_no_done", done_cnt, d0);
    ofifo_valid = 1'b1;
    push_tile(2, 11'd5, 11'd30, 11'd7, tile_len(2), 1'b1);
    do_start(11'd2, 11'd5, 11'd30, 11'd7);
    wait_done("after_abort", 200);
    tick(3);

    chk("events_left", exp_q.size(), 0);
    chk("tiles_left", tn_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_inst_seq.md
CORE_INST_SEQ -- requirements
Module: core_inst_seq

Interface
REQ-001 SHALL have parameter row, default 8, PE array rows and weight vectors per tile.
REQ-002 SHALL have parameter col, default 8, PE array columns, used for pipeline fill and drain.
REQ-003 SHALL have parameter aw, default 11, SRAM address width.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port start, input, 1, one-cycle pulse; sampled only in IDLE.
REQ-007 SHALL have port num_act, input, aw, activation vectors per tile, 1..2047; latched on accepted start.
REQ-008 SHALL have port w_base, input, aw, xmem address of the first weight vector; latched on start.
REQ-009 SHALL have port a_base, input, aw, xmem address of the first activation vector; latched on start.
REQ-010 SHALL have port p_base, input, aw, pmem address of the first psum row; latched on start.
REQ-011 SHALL have port ofifo_valid, input, 1, the core reports that an output-FIFO row is available.
REQ-012 SHALL have port inst, output, 34, registered instruction word to the core.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when the tile completes.

Function
REQ-015 inst field map SHALL be:
- [33] acc
- [32] pmem CEN_n
- [31] pmem WEN_n
- [30:20] pmem addr
- [19] xmem CEN_n
- [18] xmem WEN_n
- [17:7] xmem addr
- [6] ofifo_rd
- [5] ififo_wr
- [4] ififo_rd
- [3] l0_rd
- [2] l0_wr
- [1] execute
- [0] load
REQ-016 Idle word SHALL be 34'h1_800C_0000: all CEN_n and WEN_n high, every other bit 0.
REQ-017 inst SHALL be driven from a register; it changes only on clk rising edges.
REQ-018 FSM states SHALL be IDLE, W_L0, W_LD, A_L0, EXEC, DRAIN, ACC, FIN.
REQ-019 IDLE -> W_L0 SHALL occur on start; the configuration inputs are latched in the same cycle.
REQ-020 W_L0 SHALL last row cycles:
- xmem CEN_n=0, WEN_n=1, addr = w_base + k
- l0_wr=1 delayed one cycle to match the SRAM read latency
- k = 0..row-1
REQ-021 W_LD SHALL last row+col cycles with l0_rd=1 and load=1 for the first row cycles, then load=0 for col cycles of fill.
REQ-022 A_L0 SHALL last num_act cycles reading xmem at a_base+k, with l0_wr asserted one cycle later.
REQ-023 EXEC SHALL last num_act+row+col cycles, with l0_rd=1 and execute=1 for the first num_act cycles.
REQ-024 DRAIN SHALL behave as follows:
- each cycle with ofifo_valid=1: ofifo_rd=1
- the next cycle: pmem CEN_n=0, WEN_n=0, addr = p_base + j
- j increments per written row
- exit after num_act writes
REQ-025 In DRAIN, ofifo_valid=0 SHALL stall the state; no write is issued and j holds.
REQ-026 ACC SHALL last num_act+1 cycles:
- acc=1 throughout
- pmem CEN_n=0, WEN_n=1, addr = p_base + j for the first num_act cycles
- trailing cycle with acc=1 only, to capture the last SRAM read
REQ-027 FIN SHALL drive the idle word, pulse done for exactly one cycle, and return to IDLE next cycle.
REQ-028 Address arithmetic SHALL be modulo 2^aw; base+k past 2047 wraps to 0.
REQ-029 start while busy SHALL be ignored, with no effect on counters or latched configuration.
REQ-030 num_act=0 latched SHALL be treated as 1.
REQ-031 Exactly one of load/execute SHALL be high in any cycle, or neither.
REQ-032 xmem and pmem writes SHALL never coincide with a read of the same SRAM.

Reset
REQ-033 reset SHALL force, on the next edge and regardless of state:
- state=IDLE
- inst = idle word
- busy=0, done=0
- all counters 0
- latched configuration 0
REQ-034 reset asserted mid-tile SHALL abandon the tile; no done pulse is issued.
REQ-035 With reset and start both high in one cycle, reset SHALL win.

Verification
REQ-036 Scenario (reset): reset for 2 cycles -> inst=34'h1_800C_0000, busy=0, done=0.
REQ-037 Scenario (short tile): num_act=4, w_base=0, a_base=8, p_base=0, ofifo_valid tied 1 -> xmem reads 0..7 then 8..11; 4 pmem writes at 0..3; 5 acc cycles; done exactly 1 cycle; total cycles = 8+16+4+20+(4+1)+5+1.
REQ-038 Scenario (drain stall): num_act=3, ofifo_valid toggled 1,0,0,1,1 in DRAIN -> pmem writes at p_base+0,1,2 only one cycle after each valid; no writes during stalls.
REQ-039 Scenario (wrap): a_base=2046, num_act=4 -> xmem addresses 2046,2047,0,1.
REQ-040 Scenario (start while busy): start pulsed during EXEC with different num_act -> no change; done timing matches the original num_act.
REQ-041 Scenario (reset mid-tile): reset asserted during DRAIN -> idle word next edge; no done; a subsequent start runs a full tile correctly.
